// File: rtl/bp_be_stride_pkg.sv
// Shared types and defaults for the striding-load detector feeding the prefetch generator.
package bp_be_stride_pkg;

    typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

    function automatic int bp_vaddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 39;
            default:          return 39;
        endcase
    endfunction

    localparam int vaddr_width_gp    = bp_vaddr_width(e_bp_default_cfg);
    localparam int entries_gp        = 16;
    localparam int tag_width_gp      = 10;
    localparam int stride_width_gp   = 8;
    localparam int loop_range_gp     = 8;
    localparam int conf_width_gp     = 2;
    localparam int conf_thresh_gp    = 2;
    localparam int prefetch_depth_gp = 16;
    localparam int cooldown_width_gp = $clog2(prefetch_depth_gp + 1);

    typedef struct packed {
        logic                         valid;
        logic [tag_width_gp-1:0]      tag;
        logic [vaddr_width_gp-1:0]    last_addr;
        logic [stride_width_gp-1:0]   stride;
        logic [conf_width_gp-1:0]     conf;
        logic [cooldown_width_gp-1:0] cooldown;
    } bp_be_stride_entry_s;

    typedef struct packed {
        logic [vaddr_width_gp-1:0]  pc;
        logic [vaddr_width_gp-1:0]  eff_addr;
        logic [stride_width_gp-1:0] stride;
        logic [loop_range_gp-1:0]   loop_counter;
    } bp_be_stride_req_s;

    // A delta is usable only if it is nonzero and sign-representable in the stride field.
    function automatic logic stride_fits(input logic [vaddr_width_gp-1:0] d);
        logic [vaddr_width_gp-stride_width_gp:0] upper;
        upper = d[vaddr_width_gp-1:stride_width_gp-1];
        return ((upper == {(vaddr_width_gp-stride_width_gp+1){1'b0}}) ||
                (upper == {(vaddr_width_gp-stride_width_gp+1){1'b1}})) &&
               (d != {vaddr_width_gp{1'b0}});
    endfunction

endpackage

// File: rtl/bp_be_stride_table.sv
// Direct-mapped reference prediction table: per-PC last address, stride, confidence and cooldown.
module bp_be_stride_table
    import bp_be_stride_pkg::*;
#(
    parameter int entries_p        = entries_gp,
    parameter int tag_width_p      = tag_width_gp,
    parameter int stride_width_p   = stride_width_gp,
    parameter int conf_width_p     = conf_width_gp,
    parameter int prefetch_depth_p = prefetch_depth_gp,
    parameter int vaddr_width_p    = vaddr_width_gp,
    localparam int idx_width_lp    = $clog2(entries_p)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               clear_i,
    input  logic                               v_i,
    input  logic [idx_width_lp+tag_width_p-1:0] pc_bits_i,
    input  logic [vaddr_width_p-1:0]           eff_addr_i,
    input  logic                               issue_i,
    output logic                               hit_o,
    output logic                               match_o,
    output logic [conf_width_p-1:0]            conf_o,
    output logic                               cooldown_zero_o,
    output logic [stride_width_p-1:0]          stride_o
);

    bp_be_stride_entry_s tbl_r [entries_p];
    bp_be_stride_entry_s rd_s;
    bp_be_stride_entry_s nxt_s;

    logic [idx_width_lp-1:0]  idx_s;
    logic [tag_width_p-1:0]   tag_s;
    logic [vaddr_width_p-1:0] diff_s;
    logic                     fits_s;
    logic                     hit_s;
    logic                     match_s;
    logic [conf_width_p-1:0]  conf_inc_s;

    assign idx_s      = pc_bits_i[idx_width_lp-1:0];
    assign tag_s      = pc_bits_i[idx_width_lp +: tag_width_p];
    assign rd_s       = tbl_r[idx_s];
    assign diff_s     = eff_addr_i - rd_s.last_addr;
    assign fits_s     = stride_fits(diff_s);
    assign hit_s      = rd_s.valid & (rd_s.tag == tag_s);
    assign match_s    = hit_s & fits_s & (diff_s[stride_width_p-1:0] == rd_s.stride);
    assign conf_inc_s = (rd_s.conf == {conf_width_p{1'b1}}) ? rd_s.conf
                                                           : rd_s.conf + conf_width_p'(1);

    // A clear in the same cycle wins, so the load is treated as never having been seen.
    assign hit_o           = v_i & ~clear_i & hit_s;
    assign match_o         = hit_o & match_s;
    assign conf_o          = conf_inc_s;
    assign cooldown_zero_o = (rd_s.cooldown == {cooldown_width_gp{1'b0}});
    assign stride_o        = rd_s.stride;

    // Next contents of the indexed entry for allocate, confirm or retrain.
    always_comb begin
        nxt_s           = rd_s;
        nxt_s.last_addr = eff_addr_i;
        if (!hit_s) begin
            nxt_s.valid    = 1'b1;
            nxt_s.tag      = tag_s;
            nxt_s.stride   = {stride_width_p{1'b0}};
            nxt_s.conf     = {conf_width_p{1'b0}};
            nxt_s.cooldown = {cooldown_width_gp{1'b0}};
        end else if (match_s) begin
            nxt_s.conf = conf_inc_s;
            if (issue_i) begin
                nxt_s.cooldown = cooldown_width_gp'(prefetch_depth_p);
            end else if (rd_s.cooldown != {cooldown_width_gp{1'b0}}) begin
                nxt_s.cooldown = rd_s.cooldown - cooldown_width_gp'(1);
            end else begin
                nxt_s.cooldown = rd_s.cooldown;
            end
        end else begin
            nxt_s.stride   = fits_s ? diff_s[stride_width_p-1:0] : {stride_width_p{1'b0}};
            nxt_s.conf     = {conf_width_p{1'b0}};
            nxt_s.cooldown = {cooldown_width_gp{1'b0}};
        end
    end

    // Table storage: async reset, synchronous invalidate, single-entry write per load.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < entries_p; i++) begin
                tbl_r[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < entries_p; i++) begin
                tbl_r[i].valid <= 1'b0;
            end
        end else if (v_i) begin
            tbl_r[idx_s] <= nxt_s;
        end else begin
            tbl_r[idx_s] <= tbl_r[idx_s];
        end
    end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Stride detector top: issue decision, single-entry output register and valid/ready_and handshake.
module bp_be_stride_detector
    import bp_be_stride_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int entries_p        = entries_gp,
    parameter int tag_width_p      = tag_width_gp,
    parameter int stride_width_p   = stride_width_gp,
    parameter int loop_range_p     = loop_range_gp,
    parameter int conf_width_p     = conf_width_gp,
    parameter int conf_thresh_p    = conf_thresh_gp,
    parameter int prefetch_depth_p = prefetch_depth_gp,
    localparam int vaddr_width_p   = bp_vaddr_width(bp_params_p),
    localparam int idx_width_lp    = $clog2(entries_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      clear_i,
    input  logic                      v_i,
    input  logic [vaddr_width_p-1:0]  pc_i,
    input  logic [vaddr_width_p-1:0]  eff_addr_i,
    output logic                      v_o,
    input  logic                      ready_and_i,
    output logic [vaddr_width_p-1:0]  pc_o,
    output logic [vaddr_width_p-1:0]  eff_addr_o,
    output logic [stride_width_p-1:0] stride_o,
    output logic [loop_range_p-1:0]   loop_counter_o,
    output logic                      drop_o
);

    localparam logic [0:0] st_empty_lp = 1'b0;
    localparam logic [0:0] st_full_lp  = 1'b1;

    logic [0:0]                state_r, state_n;
    bp_be_stride_req_s         req_r, req_n;
    logic                      drop_r;
    logic                      hit_s, match_s, cooldown_zero_s;
    logic [conf_width_p-1:0]   conf_s;
    logic [stride_width_p-1:0] stride_s;
    logic                      issue_s, load_s, drop_s;

    bp_be_stride_table #(
        .entries_p       (entries_p),
        .tag_width_p     (tag_width_p),
        .stride_width_p  (stride_width_p),
        .conf_width_p    (conf_width_p),
        .prefetch_depth_p(prefetch_depth_p),
        .vaddr_width_p   (vaddr_width_p)
    ) table_u (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .clear_i        (clear_i),
        .v_i            (v_i),
        .pc_bits_i      (pc_i[idx_width_lp+tag_width_p:1]),
        .eff_addr_i     (eff_addr_i),
        .issue_i        (issue_s),
        .hit_o          (hit_s),
        .match_o        (match_s),
        .conf_o         (conf_s),
        .cooldown_zero_o(cooldown_zero_s),
        .stride_o       (stride_s)
    );

    // The table still records the issue (cooldown) even when the request itself is dropped.
    assign issue_s = hit_s & match_s & cooldown_zero_s &
                     (conf_s >= conf_width_p'(conf_thresh_p));
    assign load_s  = issue_s & ((state_r == st_empty_lp) | ready_and_i);
    assign drop_s  = issue_s & (state_r == st_full_lp) & ~ready_and_i;

    // Output register occupancy.
    always_comb begin
        state_n = state_r;
        case (state_r)
            st_empty_lp: state_n = load_s ? st_full_lp : st_empty_lp;
            st_full_lp: begin
                if (load_s) begin
                    state_n = st_full_lp;
                end else if (ready_and_i) begin
                    state_n = st_empty_lp;
                end else begin
                    state_n = st_full_lp;
                end
            end
            default: state_n = st_empty_lp;
        endcase
    end

    // Request payload captured on load, otherwise held stable.
    always_comb begin
        req_n = req_r;
        if (load_s) begin
            req_n.pc           = pc_i;
            req_n.eff_addr     = eff_addr_i;
            req_n.stride       = stride_s;
            req_n.loop_counter = loop_range_p'(prefetch_depth_p);
        end else begin
            req_n = req_r;
        end
    end

    // Output state, payload and drop pulse registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= st_empty_lp;
            req_r   <= '0;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            req_r   <= req_n;
            drop_r  <= drop_s;
        end
    end

    assign v_o            = (state_r == st_full_lp);
    assign pc_o           = req_r.pc;
    assign eff_addr_o     = req_r.eff_addr;
    assign stride_o       = req_r.stride;
    assign loop_counter_o = req_r.loop_counter;
    assign drop_o         = drop_r;

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Scoreboard bench for bp_be_stride_detector: a reference table model predicts requests and drops.
module tb_bp_be_stride_detector;
    import bp_be_stride_pkg::*;

    localparam int VA = 39;

    logic          clk_i = 1'b0;
    logic          reset_i, clear_i, v_i, ready_and_i;
    logic [VA-1:0] pc_i, eff_addr_i;
    logic          v_o, drop_o;
    logic [VA-1:0] pc_o, eff_addr_o;
    logic [7:0]    stride_o, loop_counter_o;

    always #5 clk_i = ~clk_i;

    bp_be_stride_detector dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .clear_i       (clear_i),
        .v_i           (v_i),
        .pc_i          (pc_i),
        .eff_addr_i    (eff_addr_i),
        .v_o           (v_o),
        .ready_and_i   (ready_and_i),
        .pc_o          (pc_o),
        .eff_addr_o    (eff_addr_o),
        .stride_o      (stride_o),
        .loop_counter_o(loop_counter_o),
        .drop_o        (drop_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit            m_valid [16];
    logic [9:0]    m_tag   [16];
    logic [VA-1:0] m_last  [16];
    int            m_stride[16];
    int            m_conf  [16];
    int            m_cool  [16];
    bit            m_full, m_drop;
    bp_be_stride_req_s q[$];

    // Observations taken from the DUT
    int            n_xfer_dut = 0;
    int            n_drop_dut = 0;
    logic [VA-1:0] cap_pc, cap_eff;
    logic [7:0]    cap_stride, cap_loop;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_last[i] = '0;
            m_stride[i] = 0; m_conf[i] = 0; m_cool[i] = 0;
        end
        q.delete();
        m_full = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic model_load(input logic [VA-1:0] pc, input logic [VA-1:0] addr,
                              output logic iss, output logic [7:0] st);
        int i, c;
        logic [9:0] tg;
        logic signed [VA-1:0] dd;
        longint d;
        bit fits;
        i   = int'(pc[4:1]);
        tg  = pc[14:5];
        iss = 1'b0;
        if (!m_valid[i] || m_tag[i] != tg) begin
            m_valid[i] = 1'b1; m_tag[i] = tg;
            m_stride[i] = 0; m_conf[i] = 0; m_cool[i] = 0;
        end else begin
            dd   = addr - m_last[i];
            d    = longint'(dd);
            fits = (d >= -128) && (d <= 127) && (d != 0);
            if (fits && d == longint'(m_stride[i])) begin
                c = (m_conf[i] < 3) ? m_conf[i] + 1 : 3;
                iss = (c >= 2) && (m_cool[i] == 0);
                m_cool[i] = iss ? 16 : ((m_cool[i] > 0) ? m_cool[i] - 1 : 0);
                m_conf[i] = c;
            end else begin
                m_stride[i] = fits ? int'(d) : 0;
                m_conf[i] = 0;
                m_cool[i] = 0;
            end
        end
        m_last[i] = addr;
        st = 8'(m_stride[i]);
    endtask

    // One cycle: check outputs from the last edge, drive new inputs, advance the model.
    task automatic step(input logic v, input logic [VA-1:0] pc, input logic [VA-1:0] addr,
                        input logic rdy, input logic clr);
        logic iss, ld, hs;
        logic [7:0] st;
        bp_be_stride_req_s e;
        @(negedge clk_i);
        chk("v_o", v_o, m_full);
        chk("drop_o", drop_o, m_drop);
        if (drop_o) n_drop_dut++;
        if (m_full && q.size() > 0) begin
            chk("pc_o", pc_o, q[0].pc);
            chk("eff_addr_o", eff_addr_o, q[0].eff_addr);
            chk("stride_o", stride_o, q[0].stride);
            chk("loop_counter_o", loop_counter_o, q[0].loop_counter);
        end
        if (v_o && rdy) begin
            n_xfer_dut++;
            cap_pc = pc_o; cap_eff = eff_addr_o; cap_stride = stride_o; cap_loop = loop_counter_o;
        end
        v_i = v; pc_i = pc; eff_addr_i = addr; ready_and_i = rdy; clear_i = clr;
        hs = m_full & rdy;
        if (hs && q.size() > 0) void'(q.pop_front());
        iss = 1'b0;
        st  = 8'h00;
        if (clr) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (v) begin
            model_load(pc, addr, iss, st);
        end
        ld     = iss & (!m_full | rdy);
        m_drop = iss & m_full & !rdy;
        if (ld) begin
            e.pc = pc; e.eff_addr = addr; e.stride = st; e.loop_counter = 8'd16;
            q.push_back(e);
        end
        m_full = ld ? 1'b1 : (hs ? 1'b0 : m_full);
    endtask

    localparam logic [VA-1:0] PC_A  = 39'h80000100;
    localparam logic [VA-1:0] PC_DN = 39'h80000240;
    localparam logic [VA-1:0] PC_J  = 39'h80000344;
    localparam logic [VA-1:0] PC_P  = 39'h80000408;
    localparam logic [VA-1:0] PC_Q  = 39'h8000040C;
    localparam logic [VA-1:0] PC_R  = 39'h80000410;
    localparam logic [VA-1:0] PC_S  = 39'h80000414;
    localparam logic [VA-1:0] PC_T  = 39'h80000418;
    localparam logic [VA-1:0] PC_A2 = 39'h80000600;
    localparam logic [VA-1:0] PC_B2 = 39'h80000620;
    localparam logic [VA-1:0] PC_U  = 39'h80000708;
    localparam logic [VA-1:0] Z     = 39'h0;

    initial begin
        reset_i = 1'b1; clear_i = 1'b0; v_i = 1'b0; ready_and_i = 1'b0;
        pc_i = '0; eff_addr_i = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("rst_v_o", v_o, 1'b0);
        chk("rst_drop_o", drop_o, 1'b0);
        chk("rst_pc_o", pc_o, Z);
        chk("rst_eff_addr_o", eff_addr_o, Z);
        chk("rst_stride_o", stride_o, 8'h00);
        chk("rst_loop_o", loop_counter_o, 8'h00);
        reset_i = 1'b0;

        // Ascending stride +8: issue on the 4th load, then cooldown for 16 loads
        for (int k = 0; k < 4; k++) step(1'b1, PC_A, 39'h1000 + 39'(8 * k), 1'b1, 1'b0);
        step(1'b1, PC_A, 39'h1020, 1'b1, 1'b0);
        chk("first_xfer_cnt", n_xfer_dut, 1);
        chk("first_eff_addr", cap_eff, 39'h1018);
        chk("first_pc", cap_pc, PC_A);
        chk("first_stride", cap_stride, 8'h08);
        chk("first_loop", cap_loop, 8'd16);
        for (int k = 2; k <= 16; k++) step(1'b1, PC_A, 39'h1018 + 39'(8 * k), 1'b1, 1'b0);
        chk("cooldown_no_issue", n_xfer_dut, 1);
        step(1'b1, PC_A, 39'h1018 + 39'(8 * 17), 1'b1, 1'b0);
        step(1'b0, Z, Z, 1'b1, 1'b0);
        chk("second_xfer_cnt", n_xfer_dut, 2);
        chk("second_eff_addr", cap_eff, 39'h10A0);

        // Descending stride -8
        for (int k = 0; k < 4; k++) step(1'b1, PC_DN, 39'h2040 - 39'(8 * k), 1'b1, 1'b0);
        step(1'b0, Z, Z, 1'b1, 1'b0);
        chk("desc_xfer_cnt", n_xfer_dut, 3);
        chk("desc_stride", cap_stride, 8'hF8);
        chk("desc_eff_addr", cap_eff, 39'h2028);

        // Out-of-range jump and repeated address both retrain
        step(1'b1, PC_J, 39'h4000, 1'b1, 1'b0);
        step(1'b1, PC_J, 39'h4008, 1'b1, 1'b0);
        step(1'b1, PC_J, 39'h4010, 1'b1, 1'b0);
        step(1'b1, PC_J, 39'h4210, 1'b1, 1'b0);
        step(1'b1, PC_J, 39'h4218, 1'b1, 1'b0);
        step(1'b1, PC_J, 39'h4220, 1'b1, 1'b0);
        step(1'b1, PC_J, 39'h4220, 1'b1, 1'b0);
        step(1'b1, PC_J, 39'h4228, 1'b1, 1'b0);
        step(1'b0, Z, Z, 1'b1, 1'b0);
        chk("jump_no_issue", n_xfer_dut, 3);

        // Output register full and stalled: second issue is dropped
        for (int k = 0; k < 4; k++) step(1'b1, PC_P, 39'h5000 + 39'(8 * k), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, PC_Q, 39'h6000 + 39'(16 * k), 1'b0, 1'b0);
        step(1'b0, Z, Z, 1'b0, 1'b0);
        step(1'b0, Z, Z, 1'b0, 1'b0);
        chk("drop_cnt", n_drop_dut, 1);
        step(1'b0, Z, Z, 1'b1, 1'b0);
        step(1'b0, Z, Z, 1'b1, 1'b0);
        chk("held_xfer_cnt", n_xfer_dut, 4);
        chk("held_pc", cap_pc, PC_P);
        chk("held_eff_addr", cap_eff, 39'h5018);

        // Drain and refill in the same cycle
        for (int k = 0; k < 4; k++) step(1'b1, PC_R, 39'h8000 + 39'(4 * k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, PC_S, 39'h9000 + 39'(32 * k), 1'b0, 1'b0);
        step(1'b1, PC_S, 39'h9060, 1'b1, 1'b0);
        chk("refill_first_pc", cap_pc, PC_R);
        step(1'b0, Z, Z, 1'b1, 1'b0);
        step(1'b0, Z, Z, 1'b1, 1'b0);
        chk("refill_xfer_cnt", n_xfer_dut, 6);
        chk("refill_second_pc", cap_pc, PC_S);
        chk("refill_second_stride", cap_stride, 8'h20);

        // Asynchronous reset while a request is held
        for (int k = 0; k < 4; k++) step(1'b1, PC_T, 39'hB000 + 39'(8 * k), 1'b0, 1'b0);
        step(1'b0, Z, Z, 1'b0, 1'b0);
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_rst_v_o", v_o, 1'b0);
        model_reset();
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        for (int k = 4; k < 7; k++) step(1'b1, PC_T, 39'hB000 + 39'(8 * k), 1'b1, 1'b0);
        step(1'b0, Z, Z, 1'b1, 1'b0);
        chk("post_rst_empty_table", n_xfer_dut, 6);

        // Aliasing PCs keep evicting each other
        for (int k = 0; k < 8; k++) begin
            step(1'b1, PC_A2, 39'hC000 + 39'(8 * k), 1'b1, 1'b0);
            step(1'b1, PC_B2, 39'hD000 + 39'(8 * k), 1'b1, 1'b0);
        end
        step(1'b0, Z, Z, 1'b1, 1'b0);
        chk("alias_no_issue", n_xfer_dut, 6);

        // Clear wins over a simultaneous load that would have issued
        for (int k = 0; k < 3; k++) step(1'b1, PC_U, 39'h7000 + 39'(8 * k), 1'b1, 1'b0);
        step(1'b1, PC_U, 39'h7018, 1'b1, 1'b1);
        for (int k = 4; k < 7; k++) step(1'b1, PC_U, 39'h7000 + 39'(8 * k), 1'b1, 1'b0);
        step(1'b0, Z, Z, 1'b1, 1'b0);
        step(1'b0, Z, Z, 1'b1, 1'b0);
        chk("clear_no_issue", n_xfer_dut, 6);
        chk("drop_total", n_drop_dut, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
